// File: rtl/move_stack_executor.sv
// Make/unmake engine: current board, move executor and undo stack.
// Board and move types live in move_pkg, shared with the bench.
package move_pkg;

    // Bitboard index = colour*6 + type; types N,B,R,Q,P,K = 0..5.
    typedef struct packed {
        logic [11:0][63:0] pieces;
        logic              stm;
        logic [15:0]       ply;
        logic [6:0]        ply50;
        logic [3:0]        castle;
        logic [3:0]        en_passant;
        logic [1:0]        checkmate;
    } board_t;

    // promo: 0 = none, 1..4 = N,B,R,Q.
    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        logic [2:0] promo;
    } move_t;

endpackage

module move_executor
    import move_pkg::*;
(
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   valid_in,
    input  board_t board_in,
    input  move_t  move_in,
    output board_t board_out,
    output logic   captured_out,
    output logic   valid_out
);

    logic [3:0] w_mover;
    logic [3:0] w_type;
    logic [3:0] w_dest;
    logic       w_found;
    logic       w_cap;
    logic       w_black;
    logic       w_pawn;
    logic       w_promo;
    logic [6:0] w_diff;
    board_t     w_nxt;

    // Castling rights kept when a move touches square sq.
    function automatic logic [3:0] castle_keep(input logic [5:0] sq);
        case (sq)
            6'd4:    castle_keep = 4'b1100;
            6'd7:    castle_keep = 4'b1110;
            6'd0:    castle_keep = 4'b1101;
            6'd60:   castle_keep = 4'b0011;
            6'd63:   castle_keep = 4'b1011;
            6'd56:   castle_keep = 4'b0111;
            default: castle_keep = 4'b1111;
        endcase
    endfunction

    // Find the moving piece and whether the target square is occupied.
    always_comb begin
        w_mover = 4'd0;
        w_found = 1'b0;
        w_cap   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (board_in.pieces[i][move_in.src]) begin
                w_mover = 4'(i);
                w_found = 1'b1;
            end
            if (board_in.pieces[i][move_in.dst]) begin
                w_cap = 1'b1;
            end
        end
    end

    // Classify the mover and pick the bitboard that receives the dst square.
    always_comb begin
        w_black = (w_mover >= 4'd6);
        w_type  = w_black ? (w_mover - 4'd6) : w_mover;
        w_pawn  = w_found && (w_type == 4'd4);
        w_promo = w_pawn && (move_in.promo != 3'd0)
                  && (move_in.promo <= 3'd4);
        w_diff  = {1'b0, move_in.dst} - {1'b0, move_in.src};
        if (w_promo) begin
            w_dest = (w_black ? 4'd6 : 4'd0)
                     + {1'b0, move_in.promo} - 4'd1;
        end else begin
            w_dest = w_mover;
        end
    end

    // Build the successor board.
    always_comb begin
        w_nxt = board_in;
        for (int i = 0; i < 12; i++) begin
            w_nxt.pieces[i][move_in.src] = 1'b0;
            w_nxt.pieces[i][move_in.dst] = 1'b0;
        end
        if (w_found) begin
            w_nxt.pieces[w_dest][move_in.dst] = 1'b1;
        end
        w_nxt.stm = ~board_in.stm;
        w_nxt.ply = board_in.ply + 16'd1;
        if (w_pawn || w_cap) begin
            w_nxt.ply50 = 7'd0;
        end else if (board_in.ply50 != 7'h7F) begin
            w_nxt.ply50 = board_in.ply50 + 7'd1;
        end
        w_nxt.castle = board_in.castle
                       & castle_keep(move_in.src)
                       & castle_keep(move_in.dst);
        if (w_pawn && (w_diff == 7'd16 || w_diff == 7'h70)) begin
            w_nxt.en_passant = {1'b1, move_in.dst[2:0]};
        end else begin
            w_nxt.en_passant = 4'd0;
        end
        w_nxt.checkmate = 2'b00;
    end

    // Register the result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            board_out    <= '0;
            captured_out <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            if (valid_in) begin
                board_out    <= w_nxt;
                captured_out <= w_found && w_cap;
            end
            valid_out <= valid_in;
        end
    end

endmodule

module move_stack_executor
    import move_pkg::*;
#(
    parameter int MAX_DEPTH    = 16,
    parameter int STOP_ON_MATE = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [1:0]                     cmd_in,
    input  move_t                          move_in,
    input  board_t                         board_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output board_t                         board_out,
    output logic                           captured_out,
    output logic                           valid_out,
    output logic                           err_out,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth_out,
    output logic                           full_out,
    output logic                           empty_out
);

    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    localparam logic [1:0] CMD_LOAD   = 2'd0;
    localparam logic [1:0] CMD_MAKE   = 2'd1;
    localparam logic [1:0] CMD_UNMAKE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_COMMIT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_cmd;
    move_t         r_move;
    board_t        r_board_in;
    logic          r_pend_err;
    board_t        r_board;
    logic [DW-1:0] r_depth;
    logic          r_captured;
    logic          r_valid;
    logic          r_err;
    board_t        r_rd_data;
    board_t        r_stack [MAX_DEPTH];

    logic          w_accept;
    logic          w_err;
    logic          w_full;
    logic          w_empty;
    logic [DW-1:0] w_dec;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    board_t        w_exec_board;
    logic          w_exec_cap;
    logic          w_exec_valid;

    assign w_full   = (r_depth == DW'(MAX_DEPTH));
    assign w_empty  = (r_depth == '0);
    assign w_accept = valid_in && (r_state == S_IDLE);
    assign w_dec    = r_depth - DW'(1);
    assign w_wr_idx = r_depth[AW-1:0];
    assign w_rd_idx = w_dec[AW-1:0];

    assign ready_out    = (r_state == S_IDLE);
    assign board_out    = r_board;
    assign captured_out = r_captured;
    assign valid_out    = r_valid;
    assign err_out      = r_err;
    assign depth_out    = r_depth;
    assign full_out     = w_full;
    assign empty_out    = w_empty;

    // Reject illegal commands against the state seen at acceptance.
    always_comb begin
        w_err = 1'b0;
        case (cmd_in)
            CMD_LOAD:   w_err = 1'b0;
            CMD_MAKE:   w_err = w_full
                                || ((STOP_ON_MATE != 0)
                                    && (r_board.checkmate != 2'b00));
            CMD_UNMAKE: w_err = w_empty;
            default:    w_err = 1'b1;
        endcase
    end

    move_executor u_exec (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (1'b1),
        .board_in     (r_board),
        .move_in      (r_move),
        .board_out    (w_exec_board),
        .captured_out (w_exec_cap),
        .valid_out    (w_exec_valid)
    );

    // Undo stack: push on MAKE acceptance, registered pop read on UNMAKE.
    always_ff @(posedge clk_in) begin
        if (w_accept && !w_err && cmd_in == CMD_MAKE) begin
            r_stack[w_wr_idx] <= r_board;
        end
        if (w_accept && cmd_in == CMD_UNMAKE) begin
            r_rd_data <= r_stack[w_rd_idx];
        end
    end

    // Command FSM: IDLE -> EXEC -> COMMIT, state updates at COMMIT.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cmd      <= CMD_LOAD;
            r_move     <= '0;
            r_board_in <= '0;
            r_pend_err <= 1'b0;
            r_board    <= '0;
            r_depth    <= '0;
            r_captured <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        r_cmd      <= cmd_in;
                        r_move     <= move_in;
                        r_board_in <= board_in;
                        r_pend_err <= w_err;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_state    <= S_IDLE;
                    r_valid    <= 1'b1;
                    r_err      <= r_pend_err;
                    r_captured <= 1'b0;
                    if (!r_pend_err) begin
                        case (r_cmd)
                            CMD_LOAD: begin
                                r_board <= r_board_in;
                                r_depth <= '0;
                            end
                            CMD_MAKE: begin
                                if (w_exec_valid) begin
                                    r_board    <= w_exec_board;
                                    r_captured <= w_exec_cap;
                                    r_depth    <= r_depth + DW'(1);
                                end
                            end
                            CMD_UNMAKE: begin
                                r_board <= r_rd_data;
                                r_depth <= w_dec;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_stack_executor.sv
// Directed bench for move_stack_executor: two instances cover
// MAX_DEPTH=2/STOP_ON_MATE=1 (A) and MAX_DEPTH=4/STOP_ON_MATE=0 (B).
module tb_move_stack_executor;
    import move_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] cmd;
    move_t      mv;
    board_t     bd;
    logic       va;
    logic       vb;
    logic       sel;

    logic       rdy_a, cap_a, vo_a, err_a, full_a, empty_a;
    board_t     bo_a;
    logic [1:0] dep_a;
    logic       rdy_b, cap_b, vo_b, err_b, full_b, empty_b;
    board_t     bo_b;
    logic [2:0] dep_b;

    logic       rdy, cap, vo, err, full, empty;
    board_t     bo;
    logic [2:0] dep;

    int checks = 0;
    int errors = 0;

    board_t st, b1, b2, mate, cb, cb1;

    move_stack_executor #(.MAX_DEPTH(2), .STOP_ON_MATE(1)) u_a (
        .clk_in(clk), .rst_in(rst), .cmd_in(cmd), .move_in(mv),
        .board_in(bd), .valid_in(va), .ready_out(rdy_a),
        .board_out(bo_a), .captured_out(cap_a), .valid_out(vo_a),
        .err_out(err_a), .depth_out(dep_a), .full_out(full_a),
        .empty_out(empty_a)
    );

    move_stack_executor #(.MAX_DEPTH(4), .STOP_ON_MATE(0)) u_b (
        .clk_in(clk), .rst_in(rst), .cmd_in(cmd), .move_in(mv),
        .board_in(bd), .valid_in(vb), .ready_out(rdy_b),
        .board_out(bo_b), .captured_out(cap_b), .valid_out(vo_b),
        .err_out(err_b), .depth_out(dep_b), .full_out(full_b),
        .empty_out(empty_b)
    );

    assign rdy   = sel ? rdy_b   : rdy_a;
    assign cap   = sel ? cap_b   : cap_a;
    assign vo    = sel ? vo_b    : vo_a;
    assign err   = sel ? err_b   : err_a;
    assign full  = sel ? full_b  : full_a;
    assign empty = sel ? empty_b : empty_a;
    assign bo    = sel ? bo_b    : bo_a;
    assign dep   = sel ? dep_b   : {1'b0, dep_a};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input board_t obs,
                        input board_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed ply=%0d stm=%0b ep=%0h cm=%0b p4=%h p10=%h expected ply=%0d stm=%0b ep=%0h cm=%0b p4=%h p10=%h",
                   tag, obs.ply, obs.stm, obs.en_passant, obs.checkmate,
                   obs.pieces[4], obs.pieces[10], exp.ply, exp.stm,
                   exp.en_passant, exp.checkmate, exp.pieces[4],
                   exp.pieces[10]);
        end
    endtask

    // Issue one command, check 2 busy cycles, end in the valid_out cycle.
    task automatic run(input string tag, input logic [1:0] c,
                       input logic [5:0] s, input logic [5:0] d,
                       input board_t b);
        cmd = c;
        mv  = '{src: s, dst: d, promo: 3'd0};
        bd  = b;
        va  = ~sel;
        vb  = sel;
        chk({tag, "_ready"}, 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_busy"}, 64'(rdy), 64'd0);
            chk({tag, "_novalid"}, 64'(vo), 64'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, 64'(vo), 64'd1);
        chk({tag, "_rdyback"}, 64'(rdy), 64'd1);
    endtask

    initial begin
        st = '0;
        st.pieces[0]  = 64'h0000_0000_0000_0042;
        st.pieces[1]  = 64'h0000_0000_0000_0024;
        st.pieces[2]  = 64'h0000_0000_0000_0081;
        st.pieces[3]  = 64'h0000_0000_0000_0008;
        st.pieces[4]  = 64'h0000_0000_0000_FF00;
        st.pieces[5]  = 64'h0000_0000_0000_0010;
        st.pieces[6]  = 64'h4200_0000_0000_0000;
        st.pieces[7]  = 64'h2400_0000_0000_0000;
        st.pieces[8]  = 64'h8100_0000_0000_0000;
        st.pieces[9]  = 64'h0800_0000_0000_0000;
        st.pieces[10] = 64'h00FF_0000_0000_0000;
        st.pieces[11] = 64'h1000_0000_0000_0000;
        st.castle     = 4'hF;

        b1 = st;
        b1.pieces[4]  = 64'h0000_0000_1000_EF00;
        b1.stm        = 1'b1;
        b1.ply        = 16'd1;
        b1.en_passant = 4'hC;

        b2 = b1;
        b2.pieces[10] = 64'h00EF_0010_0000_0000;
        b2.stm        = 1'b0;
        b2.ply        = 16'd2;

        mate = st;
        mate.checkmate = 2'b01;

        cb = '0;
        cb.pieces[4]  = 64'h0000_0000_1000_0000;
        cb.pieces[10] = 64'h0000_0008_0000_0000;
        cb.pieces[5]  = 64'h0000_0000_0000_0010;
        cb.pieces[11] = 64'h1000_0000_0000_0000;
        cb.ply        = 16'd10;
        cb.ply50      = 7'd5;

        cb1 = cb;
        cb1.pieces[4]  = 64'h0000_0008_0000_0000;
        cb1.pieces[10] = 64'h0;
        cb1.stm        = 1'b1;
        cb1.ply        = 16'd11;
        cb1.ply50      = 7'd0;

        sel = 1'b0;
        va  = 1'b0;
        vb  = 1'b0;
        cmd = 2'd0;
        mv  = '0;
        bd  = '0;
        rst = 1'b1;
        #2;
        chk("rst_ready", 64'(rdy), 64'd1);
        chkb("rst_board", bo, '0);
        chk("rst_depth", 64'(dep), 64'd0);
        chk("rst_valid", 64'(vo), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cap", 64'(cap), 64'd0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("load", 2'd0, 6'd0, 6'd0, st);
        chk("load_err", 64'(err), 64'd0);
        chkb("load_board", bo, st);
        chk("load_depth", 64'(dep), 64'd0);
        chk("load_empty", 64'(empty), 64'd1);

        run("make1", 2'd1, 6'd12, 6'd28, '0);
        chk("make1_err", 64'(err), 64'd0);
        chk("make1_ply", 64'(bo.ply), 64'd1);
        chk("make1_ep", 64'(bo.en_passant), 64'hC);
        chk("make1_p28", 64'(bo.pieces[4][28]), 64'd1);
        chk("make1_p12", 64'(bo.pieces[4][12]), 64'd0);
        chk("make1_depth", 64'(dep), 64'd1);
        chk("make1_cap", 64'(cap), 64'd0);
        chkb("make1_board", bo, b1);

        run("make2", 2'd1, 6'd52, 6'd36, '0);
        chk("make2_err", 64'(err), 64'd0);
        chkb("make2_board", bo, b2);
        chk("make2_full", 64'(full), 64'd1);

        run("make3", 2'd1, 6'd6, 6'd21, '0);
        chk("make3_err", 64'(err), 64'd1);
        chkb("make3_board", bo, b2);
        chk("make3_depth", 64'(dep), 64'd2);
        chk("make3_full", 64'(full), 64'd1);
        chk("make3_cap", 64'(cap), 64'd0);

        run("unmake1", 2'd2, 6'd0, 6'd0, '0);
        chk("unmake1_err", 64'(err), 64'd0);
        chkb("unmake1_board", bo, b1);
        chk("unmake1_depth", 64'(dep), 64'd1);

        run("unmake2", 2'd2, 6'd0, 6'd0, '0);
        chk("unmake2_err", 64'(err), 64'd0);
        chkb("unmake2_board", bo, st);
        chk("unmake2_empty", 64'(empty), 64'd1);

        run("unmake3", 2'd2, 6'd0, 6'd0, '0);
        chk("unmake3_err", 64'(err), 64'd1);
        chk("unmake3_depth", 64'(dep), 64'd0);
        chkb("unmake3_board", bo, st);

        run("rsvd", 2'd3, 6'd0, 6'd0, '0);
        chk("rsvd_err", 64'(err), 64'd1);

        run("mate_load", 2'd0, 6'd0, 6'd0, mate);
        run("mate_make", 2'd1, 6'd12, 6'd28, '0);
        chk("mate_err", 64'(err), 64'd1);
        chk("mate_depth", 64'(dep), 64'd0);
        chkb("mate_board", bo, mate);

        sel = 1'b1;
        run("nomate_load", 2'd0, 6'd0, 6'd0, mate);
        run("nomate_make", 2'd1, 6'd12, 6'd28, '0);
        chk("nomate_err", 64'(err), 64'd0);
        chk("nomate_depth", 64'(dep), 64'd1);
        chk("nomate_ply", 64'(bo.ply), 64'd1);
        chk("nomate_p4", bo.pieces[4], 64'h0000_0000_1000_EF00);

        run("cap_load", 2'd0, 6'd0, 6'd0, cb);
        run("cap_make", 2'd1, 6'd28, 6'd35, '0);
        chk("cap_err", 64'(err), 64'd0);
        chk("cap_flag", 64'(cap), 64'd1);
        chkb("cap_board", bo, cb1);
        run("cap_unmake", 2'd2, 6'd0, 6'd0, '0);
        chk("cap_unmake_flag", 64'(cap), 64'd0);
        chkb("cap_unmake_board", bo, cb);
        chk("cap_unmake_depth", 64'(dep), 64'd0);

        sel = 1'b0;
        run("mid_load", 2'd0, 6'd0, 6'd0, st);
        run("mid_make", 2'd1, 6'd12, 6'd28, '0);
        chk("mid_depth1", 64'(dep), 64'd1);
        cmd = 2'd1;
        mv  = '{src: 6'd52, dst: 6'd36, promo: 3'd0};
        va  = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        chk("mid_exec", 64'(rdy), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(rdy), 64'd1);
        chkb("mid_rst_board", bo, '0);
        chk("mid_rst_depth", 64'(dep), 64'd0);
        chk("mid_rst_valid", 64'(vo), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                if (vo) pulses++;
            end
            chk("mid_no_valid", 64'(pulses), 64'd0);
        end
        chk("mid_depth0", 64'(dep), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/move_stack_executor.md
# move_stack_executor

Stateful make/unmake engine for the search datapath. It holds the current `board_t` and applies `move_t` commands through an internal `move_executor` instance. Every pre-move board is pushed onto an on-chip undo stack of parametrised depth, so the search FSM can walk a line and back out of it without keeping boards itself. It sits between the search controller and the move generator and replaces direct per-ply use of `move_executor`.

## Interface
Parameters:
- `MAX_DEPTH`, default 16: undo-stack entries, which is also the maximum number of MAKEs without an UNMAKE. Legal range is 1..64.
- `STOP_ON_MATE`, default 1: when 1, a MAKE on a board whose `checkmate` field is nonzero is rejected with an error.

Ports:
- `clk_in`, input, 1: clock. This is the only clock.
- `rst_in`, input, 1: reset, asynchronous and active-high.
- `cmd_in`, input, 2: command. 0 = LOAD, 1 = MAKE, 2 = UNMAKE, 3 = reserved.
- `move_in`, input, `move_t`: the move, sampled on MAKE acceptance.
- `board_in`, input, `board_t`: the board, sampled on LOAD acceptance.
- `valid_in`, input, 1: command valid.
- `ready_out`, output, 1: block can accept a command. High only in IDLE.
- `board_out`, output, `board_t`: committed current board, registered.
- `captured_out`, output, 1: the completed MAKE captured a piece.
- `valid_out`, output, 1: one-cycle pulse when a command completes.
- `err_out`, output, 1: the completed command was rejected. Only meaningful with `valid_out`.
- `depth_out`, output, `$clog2(MAX_DEPTH+1)`: number of occupied stack entries.
- `full_out`, output, 1: `depth_out == MAX_DEPTH`. Combinational from `depth_out`.
- `empty_out`, output, 1: `depth_out == 0`. Combinational from `depth_out`.

## Operation
- The FSM has three states: IDLE, EXEC and COMMIT.
- A command is accepted on a rising edge where `valid_in && ready_out`.
  - On acceptance the FSM goes IDLE to EXEC and latches `cmd_in`, `move_in` and `board_in`.
  - The rest of the cycle follows: EXEC goes to COMMIT unconditionally, then COMMIT goes to IDLE.
  - `valid_out` is high in the cycle after the COMMIT edge, which is also the first cycle `ready_out` is high again.
- While not in IDLE, `valid_in` is ignored and nothing is queued.
- Error checks are evaluated at acceptance, against the state at that moment. Any error takes the same three-cycle path, raises `err_out` with `valid_out`, and changes nothing: `board_out`, depth and stack are untouched, and `captured_out` = 0. The error cases are:
  - MAKE with `full_out` high.
  - MAKE with `STOP_ON_MATE` = 1 and `board_out.checkmate` != 0.
  - UNMAKE with `empty_out` high.
  - `cmd_in` = 3.
- LOAD: at the COMMIT edge, `board_out` takes the latched `board_in` and depth becomes 0. Stack contents are don't-care. `captured_out` = 0.
- MAKE:
  - At the acceptance edge, `stack[depth]` is written with `board_out`.
  - `move_executor` is driven with `board_out` and the latched move, with its `valid_in` tied high. Its registered outputs are valid after the EXEC edge.
  - At the COMMIT edge, `board_out` takes `move_executor.board_out`, `captured_out` takes `move_executor.captured_out`, and depth increments.
- UNMAKE:
  - At the acceptance edge, a synchronous read of `stack[depth-1]` is issued; data is registered by the EXEC edge.
  - At the COMMIT edge, `board_out` takes the read data and depth decrements. `captured_out` = 0.
  - The restored board is bit-exact with the board before the matching MAKE, including `ply`, `ply50`, `castle`, `en_passant` and `checkmate`.
- The stack is a plain array of `MAX_DEPTH` `board_t` words with one write port and one registered read port. It has no reset, so it may be inferred as RAM.

## Timing
- Reset, asynchronous: state goes to IDLE and `depth_out` to 0. `board_out` is all zeros, and `valid_out`, `err_out` and `captured_out` are all 0. `ready_out` is 1 during and after reset.
- Reset during EXEC or COMMIT aborts the command. No `valid_out` follows, and a partially pushed stack entry is discarded because depth is 0.
- Latency from the acceptance edge to the `valid_out` cycle is 3 edges for every command. Throughput is one command per 3 cycles.
- Back-to-back operation: if `valid_in` is held high during the `valid_out` cycle, the next command is accepted at that cycle's edge.
- `board_out`, `depth_out`, `full_out` and `empty_out` change only at the COMMIT edge. They are stable and valid whenever `ready_out` = 1.
- At depth == `MAX_DEPTH` a MAKE errors without any wrap-around. At depth 0 an UNMAKE errors without any wrap-around.

## Test plan
- **LOAD:** reset, then LOAD the start position with `ply` = 0. Required: `valid_out` 3 edges after acceptance, `board_out` equals the input, `depth_out` = 0, `err_out` = 0, `empty_out` = 1.
- **MAKE:** MAKE src 12, dst 28 (e2e4). Required: `board_out.ply` = 1, `en_passant` = {1, 3'd4}, `pieces[4]` bit 28 set and bit 12 clear, `depth_out` = 1, `captured_out` = 0.
- **Stack full:** with `MAX_DEPTH` = 2, issue three MAKEs back-to-back. Required: the first two give `err_out` = 0; the third gives `err_out` = 1, `board_out` unchanged, `depth_out` = 2, `full_out` = 1. Also required: `ready_out` is low for exactly 2 cycles per command.
- **Stack empty:** following that, issue three UNMAKEs. Required: the boards after ply 1 and then the LOAD board are restored bit-exact, then the third gives `err_out` = 1 with `depth_out` = 0.
- **STOP_ON_MATE:** with `STOP_ON_MATE` = 1, LOAD a board with `checkmate` = 2'b01, then MAKE. Required: `err_out` = 1 and `depth_out` stays 0. With `STOP_ON_MATE` = 0, the same MAKE succeeds.
- **Reset mid-command:** assert `rst_in` asynchronously in the EXEC cycle of a MAKE at depth 1. Required: outputs are at their reset values immediately, no `valid_out` pulse follows, and `depth_out` = 0.
